// File: rtl/iir_pole_if.sv
// iir_pole_if: sample handshake and result bus for the iir_pole section.
// master = sample producer / result consumer, slave = the filter itself.
interface iir_pole_if;
  logic signed [24:0] Xin;
  logic               in_valid;
  logic               in_ready;
  logic signed [25:0] Yout;
  logic               out_valid;
  logic               sat;
  logic               ovr_err;

  modport master (output Xin, in_valid,
                  input  in_ready, Yout, out_valid, sat, ovr_err);
  modport slave  (input  Xin, in_valid,
                  output in_ready, Yout, out_valid, sat, ovr_err);
endinterface

// File: rtl/iir_pole.sv
// iir_pole: second-order all-pole IIR section.
//   y[n] = (Xin*1024 - A1*y[n-1] - A2*y[n-2]) >>> 10
// A single 12x26 multiplier is shared across two FSM states.
// One sample is accepted every 4 cycles.
// Optional build macro IIR_POLE_SAT_EN:
//   defined   -> the result is clamped to 26-bit signed and sat flags the clip.
//   undefined -> the result wraps to 26 bits and sat stays 0.
module iir_pole #(
  parameter logic signed [11:0] COE_A1 = -12'sd1870,
  parameter logic signed [11:0] COE_A2 = 12'sd850
) (
  input  logic         clk,
  input  logic         rst_n,
  iir_pole_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, MUL1, MUL2, DONE} state_t;

  localparam logic signed [39:0] YMAX = 40'sd33554431;
  localparam logic signed [39:0] YMIN = -40'sd33554432;

  state_t             r_state;
  logic signed [39:0] r_acc;
  logic signed [25:0] r_y1, r_y2, r_yout;
  logic               r_out_valid, r_sat, r_ovr_err;

  logic signed [11:0] w_coef;
  logic signed [25:0] w_yop;
  logic signed [37:0] w_prod;
  logic signed [39:0] w_shift;
  logic signed [25:0] w_result;
  logic               w_clip;

  // Shared multiplier: A1*Y1 in MUL1, A2*Y2 otherwise.
  always_comb begin
    w_coef = (r_state == MUL1) ? COE_A1 : COE_A2;
    w_yop  = (r_state == MUL1) ? r_y1   : r_y2;
    w_prod = 38'(w_coef) * 38'(w_yop);
  end

  assign w_shift = r_acc >>> 10;

`ifdef IIR_POLE_SAT_EN
  // Clamp the floored result into the 26-bit signed output range.
  always_comb begin
    w_result = w_shift[25:0];
    w_clip   = 1'b0;
    if (w_shift > YMAX) begin
      w_result = YMAX[25:0];
      w_clip   = 1'b1;
    end else if (w_shift < YMIN) begin
      w_result = YMIN[25:0];
      w_clip   = 1'b1;
    end
  end
`else
  logic w_unused_hi;
  assign w_unused_hi = ^{w_shift[39:26], YMAX, YMIN};
  // Two's-complement wrap: keep the low 26 bits.
  always_comb begin
    w_result = w_shift[25:0];
    w_clip   = 1'b0;
  end
`endif

  // Control FSM, accumulator, feedback history and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_y1        <= '0;
      r_y2        <= '0;
      r_yout      <= '0;
      r_out_valid <= 1'b0;
      r_sat       <= 1'b0;
      r_ovr_err   <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (bus.in_valid && r_state != IDLE) r_ovr_err <= 1'b1;
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_acc   <= {{5{bus.Xin[24]}}, bus.Xin, 10'b0};
          r_state <= MUL1;
        end
        MUL1: begin
          r_acc   <= r_acc - {{2{w_prod[37]}}, w_prod};
          r_state <= MUL2;
        end
        MUL2: begin
          r_acc   <= r_acc - {{2{w_prod[37]}}, w_prod};
          r_state <= DONE;
        end
        DONE: begin
          r_yout      <= w_result;
          r_y2        <= r_y1;
          r_y1        <= w_result;
          r_sat       <= w_clip;
          r_out_valid <= 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.Yout      = r_yout;
  assign bus.out_valid = r_out_valid;
  assign bus.sat       = r_sat;
  assign bus.ovr_err   = r_ovr_err;

endmodule

// File: doc/iir_pole.md
IIR_POLE -- requirements
Module: iir_pole

Interface
REQ-001 SHALL have parameter COE_A1, default -1870, signed 12-bit feedback coefficient a1 in Q10 (a0 = 1024 implied).
REQ-002 SHALL have parameter COE_A2, default 850, signed 12-bit feedback coefficient a2 in Q10.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port Xin  input  signed 25  zero-section (numerator) sum feeding this pole section.
REQ-006 SHALL have port in_valid  input  1  Xin qualifier, sampled only when in_ready=1.
REQ-007 SHALL have port in_ready  output  1  high only in state IDLE.
REQ-008 SHALL have port Yout  output  signed 26  filter output y[n], registered.
REQ-009 SHALL have port out_valid  output  1  one-cycle pulse marking a new Yout.
REQ-010 SHALL have port sat  output  1  high with out_valid when y[n] was clipped.
REQ-011 SHALL have port ovr_err  output  1  sticky; set when in_valid=1 while in_ready=0.

Function
REQ-012 SHALL compute y[n] = (Xin*1024 - COE_A1*y[n-1] - COE_A2*y[n-2]) >>> 10, arithmetic shift (floor; -1 >>> 10 = -1).
REQ-013 SHALL use one shared 12x26 signed multiplier, time-multiplexed by the FSM; accumulator 40-bit signed, no internal overflow.
REQ-014 SHALL implement FSM states IDLE, MUL1, MUL2, DONE.
REQ-015 IDLE: in_valid=1 -> latch Xin, acc <= Xin*1024 sign-extended, go MUL1; else stay.
REQ-016 MUL1: acc <= acc - COE_A1*Y1; go MUL2.  MUL2: acc <= acc - COE_A2*Y2; go DONE.
REQ-017 DONE: Yout <= result, Y2 <= Y1, Y1 <= result, out_valid=1, sat updated; go IDLE.
REQ-018 SHALL keep feedback registers Y1, Y2 (26-bit) equal to the stored result, i.e. post-saturation (or post-wrap) value.
REQ-019 Latency: in_valid accepted at edge T -> out_valid high in the cycle after edge T+3; max throughput 1 sample per 4 cycles.
REQ-020 in_valid while in_ready=0 SHALL be ignored (sample dropped, state unaffected) and SHALL set ovr_err.
REQ-021 in_valid in the DONE->IDLE cycle is not accepted (in_ready=0 in DONE); accepted the next cycle if still high.
REQ-022 Yout, sat SHALL hold their value between out_valid pulses.

Reset
REQ-023 rst_n low SHALL asynchronously force state IDLE, acc=0, Y1=Y2=0, Yout=0, out_valid=0, sat=0, ovr_err=0; in_ready=1 during and after reset.
REQ-024 Reset mid-computation SHALL discard the sample: no out_valid, feedback history cleared.

Configuration
REQ-025 Macro IIR_POLE_SAT_EN defined: result = acc>>>10 clamped to [-33554432, 33554431], sat=1 when clamped.
REQ-026 Macro undefined: result = low 26 bits of acc>>>10 (two's-complement wrap), sat tied 0.

Verification
REQ-027 Reset: rst_n=0 with random Xin/in_valid -> Yout=0, out_valid=0, sat=0, ovr_err=0, in_ready=1.
REQ-028 Impulse (defaults): Xin=102400 then Xin=0, 0, each accepted when in_ready -> Yout = 102400, 187000, 256494; sat=0; each out_valid 4 cycles after acceptance.
REQ-029 Saturation (SAT_EN defined): Xin=16777215 twice -> Yout=16777215 (sat=0), then 33554431 (sat=1); undefined -> second Yout wraps negative, sat=0.
REQ-030 Overrun: in_valid held high 8 cycles with Xin=1000 -> exactly 2 samples accepted, ovr_err=1 and stays 1 until reset.
REQ-031 Reset mid-run: after Xin=102400 accepted, drop rst_n during MUL2 -> no out_valid; after release, Xin=0 -> Yout=0.
REQ-032 Negative floor: fresh after reset, Xin=-1 -> Yout=-1; next Xin=0 -> Yout=-2 (acc=-1870, floor).
